// File: rtl/wired_fcc_iq.sv
// rtl/wired_fcc_iq.sv - in-order issue queue and initiator for the FPU fcc execution engine
//
// Purpose:
//   Holds decoded fcc-class instructions (movgr2cf, movcf2gr, fcmp.cond.s,
//   bceqz/bcnez, fsel, fclass.s) from dispatch, captures missing source
//   operands from wakeup broadcasts, issues the oldest entry once both of its
//   sources are ready, and pairs each in-order fcc response with the ROB id of
//   the request that produced it.
//
// Optional feature:
//   WIRED_FCC_IQ_BYPASS_EN - when defined, a dispatch into an empty queue whose
//   sources are all ready (same-cycle wakeup included) issues in the same cycle
//   without being written into the queue.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   flush_i           pipeline flush, wins over every other event in its cycle
//   disp_*            dispatch handshake, payload, ROB id, source tags/ready
//   wkup_*            WKUP_CNT wakeup broadcast ports (valid, tag, data)
//   ex_req_*          request handshake towards the fcc unit
//   ex_resp_*         response handshake from the fcc unit
//   wb_*              writeback handshake (response plus ROB id)

package wired_fcc_iq_pkg;

  localparam logic [3:0] FCC_OP_MOVGR2CF = 4'd0;
  localparam logic [3:0] FCC_OP_MOVCF2GR = 4'd1;
  localparam logic [3:0] FCC_OP_FCMP     = 4'd2;
  localparam logic [3:0] FCC_OP_BCEQZ    = 4'd3;
  localparam logic [3:0] FCC_OP_BCNEZ    = 4'd4;
  localparam logic [3:0] FCC_OP_FSEL     = 4'd5;
  localparam logic [3:0] FCC_OP_FCLASS   = 4'd6;

  typedef struct packed {
    logic [3:0]  op;
    logic [4:0]  cond;   // fcmp condition code
    logic [2:0]  cd;     // condition-flag register index
    logic [31:0] r0;
    logic [31:0] r1;
  } iq_fcc_req_t;

  typedef struct packed {
    logic [31:0] data;
    logic        fcc;
  } iq_fcc_resp_t;

endpackage

module wired_fcc_iq
  import wired_fcc_iq_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int INFLIGHT = 2,
  parameter int RID_W    = 6,
  parameter int WKUP_CNT = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush_i,
  input  logic                      disp_valid_i,
  output logic                      disp_ready_o,
  input  iq_fcc_req_t               disp_req_i,
  input  logic [RID_W-1:0]          disp_rid_i,
  input  logic [2*RID_W-1:0]        disp_src_tag_i,
  input  logic [1:0]                disp_src_rdy_i,
  input  logic [WKUP_CNT-1:0]       wkup_valid_i,
  input  logic [WKUP_CNT*RID_W-1:0] wkup_tag_i,
  input  logic [WKUP_CNT*32-1:0]    wkup_data_i,
  output logic                      ex_req_valid_o,
  input  logic                      ex_req_ready_i,
  output iq_fcc_req_t               ex_req_o,
  input  logic                      ex_resp_valid_i,
  output logic                      ex_resp_ready_o,
  input  iq_fcc_resp_t              ex_resp_i,
  output logic                      wb_valid_o,
  input  logic                      wb_ready_i,
  output logic [RID_W-1:0]          wb_rid_o,
  output iq_fcc_resp_t              wb_resp_o
);

  localparam int IDX_W    = $clog2(DEPTH);
  localparam int PTR_W    = IDX_W + 1;
  localparam int IF_IDX_W = $clog2(INFLIGHT);
  localparam int IF_PTR_W = IF_IDX_W + 1;

  typedef struct packed {
    logic                  valid;
    logic [1:0]            rdy;
    logic [1:0][RID_W-1:0] tag;   // tag[0] belongs to r0, tag[1] to r1
    logic [RID_W-1:0]      rid;
    iq_fcc_req_t           req;
  } ent_t;

  ent_t             ent_q [DEPTH];
  ent_t             ent_d [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;

  logic [RID_W-1:0]    if_rid_q [INFLIGHT];
  logic [IF_PTR_W-1:0] if_head_q, if_head_d;
  logic [IF_PTR_W-1:0] if_tail_q, if_tail_d;

  logic [IDX_W-1:0]    head_idx, tail_idx;
  logic                q_empty, q_full;
  logic                if_empty, if_full;
  logic                head_issue;
  logic                bypass_fire;
  logic                enq, deq;
  logic                if_push, if_pop;
  logic [RID_W-1:0]    if_push_rid;

  iq_fcc_req_t         disp_req_m;
  logic [1:0]          disp_rdy_m;

  // Wakeup lookup: {hit, data}. Ports are scanned from the top down so the
  // lowest matching index is the one left in the result.
  function automatic logic [32:0] wkup_lookup(input logic [RID_W-1:0] tag);
    logic [32:0] res;
    res = '0;
    for (int p = WKUP_CNT - 1; p >= 0; p--) begin
      if (wkup_valid_i[p] && (wkup_tag_i[p*RID_W +: RID_W] == tag)) begin
        res = {1'b1, wkup_data_i[p*32 +: 32]};
      end
    end
    return res;
  endfunction

  // ---------------------------------------------------------------------------
  // Queue status
  // ---------------------------------------------------------------------------
  assign head_idx = head_q[IDX_W-1:0];
  assign tail_idx = tail_q[IDX_W-1:0];
  assign q_empty  = (head_q == tail_q);
  assign q_full   = (head_idx == tail_idx) && (head_q[IDX_W] != tail_q[IDX_W]);

  assign if_empty = (if_head_q == if_tail_q);
  assign if_full  = (if_head_q[IF_IDX_W-1:0] == if_tail_q[IF_IDX_W-1:0]) &&
                    (if_head_q[IF_IDX_W] != if_tail_q[IF_IDX_W]);

  // ---------------------------------------------------------------------------
  // Dispatch payload merged with same-cycle wakeups
  // ---------------------------------------------------------------------------
  always_comb begin
    logic [32:0] hit;
    hit        = '0;
    disp_req_m = disp_req_i;
    disp_rdy_m = disp_src_rdy_i;
    for (int s = 0; s < 2; s++) begin
      if (!disp_src_rdy_i[s]) begin
        hit = wkup_lookup(disp_src_tag_i[s*RID_W +: RID_W]);
        if (hit[32]) begin
          disp_rdy_m[s] = 1'b1;
          if (s == 0) disp_req_m.r0 = hit[31:0];
          else        disp_req_m.r1 = hit[31:0];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Issue selection
  // ---------------------------------------------------------------------------
  assign head_issue = ent_q[head_idx].valid && (&ent_q[head_idx].rdy) && !if_full;

`ifdef WIRED_FCC_IQ_BYPASS_EN
  // An empty queue means no older entry can be skipped, so a fully ready
  // dispatch may go straight to the fcc unit.
  assign bypass_fire = q_empty && disp_valid_i && (&disp_rdy_m) && !if_full &&
                       ex_req_ready_i;
`else
  assign bypass_fire = 1'b0;
`endif

  assign disp_ready_o   = !q_full;
  assign ex_req_valid_o = head_issue || bypass_fire;

  always_comb begin
    ex_req_o = '0;
    if (ent_q[head_idx].valid) begin
      ex_req_o = ent_q[head_idx].req;
    end else if (bypass_fire) begin
      ex_req_o = disp_req_m;
    end
  end

  assign deq         = head_issue && ex_req_ready_i;
  assign enq         = disp_valid_i && !q_full && !bypass_fire;
  assign if_push     = ex_req_valid_o && ex_req_ready_i;
  assign if_push_rid = bypass_fire ? disp_rid_i : ent_q[head_idx].rid;

  // ---------------------------------------------------------------------------
  // Response / writeback pairing
  // ---------------------------------------------------------------------------
  assign ex_resp_ready_o = wb_ready_i;
  assign wb_valid_o      = ex_resp_valid_i;
  assign wb_resp_o       = ex_resp_i;
  // Stale FIFO slots are hidden so an emptied FIFO reads as zero.
  assign wb_rid_o        = if_empty ? '0 : if_rid_q[if_head_q[IF_IDX_W-1:0]];
  assign if_pop          = ex_resp_valid_i && wb_ready_i && !if_empty;

  // ---------------------------------------------------------------------------
  // Next-state: wakeup capture, dequeue, enqueue, flush
  // ---------------------------------------------------------------------------
  always_comb begin
    logic [32:0] hit;
    hit       = '0;
    ent_d     = ent_q;
    head_d    = head_q + PTR_W'(deq);
    tail_d    = tail_q + PTR_W'(enq);
    if_head_d = if_head_q + IF_PTR_W'(if_pop);
    if_tail_d = if_tail_q + IF_PTR_W'(if_push);

    for (int e = 0; e < DEPTH; e++) begin
      for (int s = 0; s < 2; s++) begin
        if (ent_q[e].valid && !ent_q[e].rdy[s]) begin
          hit = wkup_lookup(ent_q[e].tag[s]);
          if (hit[32]) begin
            ent_d[e].rdy[s] = 1'b1;
            if (s == 0) ent_d[e].req.r0 = hit[31:0];
            else        ent_d[e].req.r1 = hit[31:0];
          end
        end
      end
    end

    if (deq) begin
      ent_d[head_idx].valid = 1'b0;
    end

    // The slot at the tail is never the head being dequeued unless the queue
    // is empty, in which case there is no dequeue; ordering here is safe.
    if (enq) begin
      ent_d[tail_idx].valid = 1'b1;
      ent_d[tail_idx].rdy   = disp_rdy_m;
      ent_d[tail_idx].tag   = disp_src_tag_i;
      ent_d[tail_idx].rid   = disp_rid_i;
      ent_d[tail_idx].req   = disp_req_m;
    end

    if (flush_i) begin
      head_d    = '0;
      tail_d    = '0;
      if_head_d = '0;
      if_tail_d = '0;
      for (int e = 0; e < DEPTH; e++) begin
        ent_d[e].valid = 1'b0;
        ent_d[e].rdy   = 2'b00;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q    <= '0;
      tail_q    <= '0;
      if_head_q <= '0;
      if_tail_q <= '0;
      for (int e = 0; e < DEPTH; e++) begin
        ent_q[e] <= '0;
      end
    end else begin
      head_q    <= head_d;
      tail_q    <= tail_d;
      if_head_q <= if_head_d;
      if_tail_q <= if_tail_d;
      ent_q     <= ent_d;
    end
  end

  // In-flight ROB id storage; only the pointers need clearing on reset/flush.
  always_ff @(posedge clk) begin
    if (!rst && !flush_i && if_push) begin
      if_rid_q[if_tail_q[IF_IDX_W-1:0]] <= if_push_rid;
    end
  end

  // A response with nothing outstanding means the fcc unit lost sync with us.
  resp_without_request: assert property (
    @(posedge clk) disable iff (rst || flush_i) !(ex_resp_valid_i && if_empty)
  );

endmodule

// File: tb/tb_wired_fcc_iq.sv
// tb/tb_wired_fcc_iq.sv - directed, table-driven bench for wired_fcc_iq
module tb_wired_fcc_iq;
  import wired_fcc_iq_pkg::*;

  localparam int RID_W    = 6;
  localparam int WKUP_CNT = 2;

  logic                      clk = 1'b0;
  logic                      rst;
  logic                      flush_i;
  logic                      disp_valid_i;
  logic                      disp_ready_o;
  iq_fcc_req_t               disp_req_i;
  logic [RID_W-1:0]          disp_rid_i;
  logic [2*RID_W-1:0]        disp_src_tag_i;
  logic [1:0]                disp_src_rdy_i;
  logic [WKUP_CNT-1:0]       wkup_valid_i;
  logic [WKUP_CNT*RID_W-1:0] wkup_tag_i;
  logic [WKUP_CNT*32-1:0]    wkup_data_i;
  logic                      ex_req_valid_o;
  logic                      ex_req_ready_i;
  iq_fcc_req_t               ex_req_o;
  logic                      ex_resp_valid_i;
  logic                      ex_resp_ready_o;
  iq_fcc_resp_t              ex_resp_i;
  logic                      wb_valid_o;
  logic                      wb_ready_i;
  logic [RID_W-1:0]          wb_rid_o;
  iq_fcc_resp_t              wb_resp_o;

  int total = 0;
  int bad   = 0;

  wired_fcc_iq #(.DEPTH(4), .INFLIGHT(2), .RID_W(RID_W), .WKUP_CNT(WKUP_CNT)) dut (
    .clk(clk), .rst(rst), .flush_i(flush_i),
    .disp_valid_i(disp_valid_i), .disp_ready_o(disp_ready_o), .disp_req_i(disp_req_i),
    .disp_rid_i(disp_rid_i), .disp_src_tag_i(disp_src_tag_i), .disp_src_rdy_i(disp_src_rdy_i),
    .wkup_valid_i(wkup_valid_i), .wkup_tag_i(wkup_tag_i), .wkup_data_i(wkup_data_i),
    .ex_req_valid_o(ex_req_valid_o), .ex_req_ready_i(ex_req_ready_i), .ex_req_o(ex_req_o),
    .ex_resp_valid_i(ex_resp_valid_i), .ex_resp_ready_o(ex_resp_ready_o), .ex_resp_i(ex_resp_i),
    .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i), .wb_rid_o(wb_rid_o), .wb_resp_o(wb_resp_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]       rdy;
    logic [RID_W-1:0] tag0, tag1;
    logic [1:0]       wv;
    logic [RID_W-1:0] wt0, wt1;
    logic [31:0]      wd0, wd1;
    logic [31:0]      r0, r1;
    logic [31:0]      exp_r0, exp_r1;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", name, act, exp);
    end
  endtask

  function automatic iq_fcc_req_t mk_req(input logic [3:0] op, input logic [31:0] r0,
                                         input logic [31:0] r1);
    iq_fcc_req_t r;
    r.op   = op;
    r.cond = 5'h4;
    r.cd   = 3'h1;
    r.r0   = r0;
    r.r1   = r1;
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    flush_i         = 1'b0;
    disp_valid_i    = 1'b0;
    disp_req_i      = '0;
    disp_rid_i      = '0;
    disp_src_tag_i  = '0;
    disp_src_rdy_i  = 2'b00;
    wkup_valid_i    = '0;
    wkup_tag_i      = '0;
    wkup_data_i     = '0;
    ex_req_ready_i  = 1'b0;
    ex_resp_valid_i = 1'b0;
    ex_resp_i       = '0;
    wb_ready_i      = 1'b1;
  endtask

  task automatic dispatch(input logic [RID_W-1:0] rid, input iq_fcc_req_t req,
                          input logic [1:0] rdy, input logic [RID_W-1:0] t0,
                          input logic [RID_W-1:0] t1);
    disp_valid_i   = 1'b1;
    disp_rid_i     = rid;
    disp_req_i     = req;
    disp_src_rdy_i = rdy;
    disp_src_tag_i = {t1, t0};
  endtask

  task automatic no_dispatch();
    disp_valid_i   = 1'b0;
    disp_src_rdy_i = 2'b00;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    iq_fcc_resp_t rsp;

    // {rdy, tag0, tag1, wv, wt0, wt1, wd0, wd1, r0, r1, exp_r0, exp_r1}
    vecs[0] = '{2'b11, 6'd1, 6'd2, 2'b00, 6'd0, 6'd0, 32'h0, 32'h0,
                32'hA0A0_0001, 32'hB0B0_0001, 32'hA0A0_0001, 32'hB0B0_0001};
    vecs[1] = '{2'b10, 6'd3, 6'd0, 2'b01, 6'd3, 6'd0, 32'hD0D0_D0D0, 32'h0,
                32'hDEAD_0000, 32'hB0B0_0002, 32'hD0D0_D0D0, 32'hB0B0_0002};
    vecs[2] = '{2'b01, 6'd0, 6'd5, 2'b10, 6'd0, 6'd5, 32'h0, 32'hD1D1_D1D1,
                32'hA0A0_0003, 32'hDEAD_0001, 32'hA0A0_0003, 32'hD1D1_D1D1};
    vecs[3] = '{2'b00, 6'd6, 6'd7, 2'b11, 6'd7, 6'd6, 32'hD0D0_D0D0, 32'hD1D1_D1D1,
                32'hDEAD_0002, 32'hDEAD_0003, 32'hD1D1_D1D1, 32'hD0D0_D0D0};
    vecs[4] = '{2'b10, 6'd8, 6'd0, 2'b11, 6'd8, 6'd8, 32'h1111_1111, 32'h2222_2222,
                32'hDEAD_0004, 32'hB0B0_0005, 32'h1111_1111, 32'hB0B0_0005};
    vecs[5] = '{2'b11, 6'd3, 6'd4, 2'b11, 6'd3, 6'd4, 32'h3333_3333, 32'h4444_4444,
                32'hA0A0_0006, 32'hB0B0_0006, 32'hA0A0_0006, 32'hB0B0_0006};

    idle_inputs();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("rst_disp_ready", disp_ready_o, 1);
    chk("rst_ex_req_valid", ex_req_valid_o, 0);
    chk("rst_ex_req", ex_req_o, 0);
    chk("rst_wb_valid", wb_valid_o, 0);
    chk("rst_wb_rid", wb_rid_o, 0);
    step();

    // 1: fcmp, both ready, rid 5
    ex_req_ready_i = 1'b1;
    dispatch(6'd5, mk_req(FCC_OP_FCMP, 32'h3F80_0000, 32'h4000_0000), 2'b11, 6'd0, 6'd0);
    #1;
    chk("t1_no_issue_same_cycle", ex_req_valid_o, 0);
    step();
    no_dispatch();
    #1;
    chk("t1_issue_valid", ex_req_valid_o, 1);
    chk("t1_issue_req", ex_req_o, mk_req(FCC_OP_FCMP, 32'h3F80_0000, 32'h4000_0000));
    step();
    rsp.data = 32'h0000_0001;
    rsp.fcc  = 1'b1;
    ex_resp_valid_i = 1'b1;
    ex_resp_i       = rsp;
    #1;
    chk("t1_req_after_issue", ex_req_valid_o, 0);
    chk("t1_wb_valid", wb_valid_o, 1);
    chk("t1_wb_rid", wb_rid_o, 5);
    chk("t1_wb_resp", wb_resp_o, rsp);
    chk("t1_resp_ready", ex_resp_ready_o, 1);
    step();
    ex_resp_valid_i = 1'b0;
    ex_resp_i       = '0;
    #1;
    chk("t1_wb_rid_drained", wb_rid_o, 0);

    // 2: fsel waiting on r1 tag 9; both wakeup ports match, port 0 wins
    dispatch(6'd7, mk_req(FCC_OP_FSEL, 32'h0000_0011, 32'h0), 2'b01, 6'd0, 6'd9);
    step();
    no_dispatch();
    #1;
    chk("t2_wait_1", ex_req_valid_o, 0);
    step();
    wkup_valid_i = 2'b11;
    wkup_tag_i   = {6'd9, 6'd9};
    wkup_data_i  = {32'h4120_0000, 32'h3F80_0000};
    #1;
    chk("t2_wait_wakeup_cycle", ex_req_valid_o, 0);
    step();
    wkup_valid_i = '0;
    #1;
    chk("t2_issue_valid", ex_req_valid_o, 1);
    chk("t2_issue_r1", ex_req_o.r1, 32'h3F80_0000);
    chk("t2_issue_r0", ex_req_o.r0, 32'h0000_0011);
    step();
    ex_resp_valid_i = 1'b1;
    #1;
    chk("t2_wb_rid", wb_rid_o, 7);
    step();
    ex_resp_valid_i = 1'b0;

    // 3: fill the queue with ready held low, then drain in order
    ex_req_ready_i = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      dispatch(RID_W'(k), mk_req(FCC_OP_FCLASS, 32'(k), 32'h0), 2'b11, 6'd0, 6'd0);
      step();
      chk($sformatf("t3_disp_ready_after_%0d", k), disp_ready_o, (k < 4) ? 1 : 0);
    end
    no_dispatch();
    ex_req_ready_i = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      ex_resp_valid_i = (k > 1);
      #1;
      chk($sformatf("t3_issue_valid_%0d", k), ex_req_valid_o, 1);
      chk($sformatf("t3_issue_order_%0d", k), ex_req_o.r0, k);
      if (k > 1) chk($sformatf("t3_wb_rid_%0d", k - 1), wb_rid_o, k - 1);
      if (k == 2) chk("t3_disp_ready_reopened", disp_ready_o, 1);
      step();
    end
    ex_resp_valid_i = 1'b1;
    #1;
    chk("t3_drained_valid", ex_req_valid_o, 0);
    chk("t3_wb_rid_4", wb_rid_o, 4);
    step();
    ex_resp_valid_i = 1'b0;

    // 4: in-flight limit of two blocks the third issue until a response
    ex_req_ready_i = 1'b1;
    dispatch(6'd10, mk_req(FCC_OP_MOVGR2CF, 32'd10, 32'h0), 2'b11, 6'd0, 6'd0);
    step();
    dispatch(6'd11, mk_req(FCC_OP_MOVGR2CF, 32'd11, 32'h0), 2'b11, 6'd0, 6'd0);
    #1;
    chk("t4_first_issue", ex_req_o.r0, 10);
    step();
    dispatch(6'd12, mk_req(FCC_OP_MOVGR2CF, 32'd12, 32'h0), 2'b11, 6'd0, 6'd0);
    step();
    no_dispatch();
    #1;
    chk("t4_blocked_full_inflight", ex_req_valid_o, 0);
    ex_resp_valid_i = 1'b1;
    #1;
    chk("t4_blocked_during_pop", ex_req_valid_o, 0);
    chk("t4_wb_rid_10", wb_rid_o, 10);
    step();
    ex_resp_valid_i = 1'b0;
    #1;
    chk("t4_unblocked_valid", ex_req_valid_o, 1);
    chk("t4_unblocked_req", ex_req_o.r0, 12);
    step();
    ex_resp_valid_i = 1'b1;
    #1;
    chk("t4_wb_rid_11", wb_rid_o, 11);
    step();
    #1;
    chk("t4_wb_rid_12", wb_rid_o, 12);
    step();
    ex_resp_valid_i = 1'b0;

    // 5: flush with three queued and one in flight
    ex_req_ready_i = 1'b1;
    dispatch(6'd20, mk_req(FCC_OP_BCEQZ, 32'd20, 32'h0), 2'b11, 6'd0, 6'd0);
    step();
    dispatch(6'd21, mk_req(FCC_OP_BCEQZ, 32'd21, 32'h0), 2'b11, 6'd0, 6'd0);
    step();
    ex_req_ready_i = 1'b0;
    dispatch(6'd22, mk_req(FCC_OP_BCEQZ, 32'd22, 32'h0), 2'b11, 6'd0, 6'd0);
    step();
    dispatch(6'd23, mk_req(FCC_OP_BCEQZ, 32'd23, 32'h0), 2'b11, 6'd0, 6'd0);
    step();
    dispatch(6'd99, mk_req(FCC_OP_BCEQZ, 32'd99, 32'h0), 2'b11, 6'd0, 6'd0);
    ex_req_ready_i = 1'b1;
    flush_i        = 1'b1;
    step();
    flush_i        = 1'b0;
    no_dispatch();
    ex_req_ready_i = 1'b0;
    #1;
    chk("t5_ex_req_valid", ex_req_valid_o, 0);
    chk("t5_ex_req", ex_req_o, 0);
    chk("t5_wb_valid", wb_valid_o, 0);
    chk("t5_wb_rid", wb_rid_o, 0);
    chk("t5_disp_ready", disp_ready_o, 1);
    step();
    ex_req_ready_i = 1'b1;
    dispatch(6'd30, mk_req(FCC_OP_BCNEZ, 32'd30, 32'h0), 2'b11, 6'd0, 6'd0);
    #1;
    chk("t5_empty_after_flush", ex_req_valid_o, 0);
    step();
    no_dispatch();
    #1;
    chk("t5_post_flush_req", ex_req_o.r0, 30);
    step();
    ex_resp_valid_i = 1'b1;
    #1;
    chk("t5_no_stale_rid", wb_rid_o, 30);
    step();
    ex_resp_valid_i = 1'b0;

    // 6: same-cycle dispatch wakeup table
    ex_req_ready_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      dispatch(RID_W'(40 + i), mk_req(FCC_OP_FCMP, vecs[i].r0, vecs[i].r1), vecs[i].rdy,
               vecs[i].tag0, vecs[i].tag1);
      wkup_valid_i = vecs[i].wv;
      wkup_tag_i   = {vecs[i].wt1, vecs[i].wt0};
      wkup_data_i  = {vecs[i].wd1, vecs[i].wd0};
      #1;
      chk($sformatf("v%0d_no_same_cycle_issue", i), ex_req_valid_o, 0);
      step();
      no_dispatch();
      wkup_valid_i = '0;
      #1;
      chk($sformatf("v%0d_issue_valid", i), ex_req_valid_o, 1);
      chk($sformatf("v%0d_r0", i), ex_req_o.r0, vecs[i].exp_r0);
      chk($sformatf("v%0d_r1", i), ex_req_o.r1, vecs[i].exp_r1);
      step();
      ex_resp_valid_i = 1'b1;
      #1;
      chk($sformatf("v%0d_wb_rid", i), wb_rid_o, 40 + i);
      step();
      ex_resp_valid_i = 1'b0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wired_fcc_iq.md
Name: wired_fcc_iq

Overview:
- In-order issue queue and initiator for the FPU fcc execution engine.
- Accepts decoded fcc-class instructions from dispatch: movgr2cf, movcf2gr, fcmp.cond.s, bceqz/bcnez, fsel, fclass.s.
- Captures source operands from the register file or from wakeup broadcasts, and issues the oldest entry once its operands are ready.
- Pairs each response from the fcc unit with its destination ROB id and forwards it to writeback.

Parameters:
- DEPTH, 4, queue entries; power of two, at least 2.
- INFLIGHT, 2, maximum issued-but-unanswered requests; power of two.
- RID_W, 6, ROB/physical tag width.
- WKUP_CNT, 2, number of wakeup broadcast ports.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- flush_i  in  1  pipeline flush; same-cycle priority over all other events.
- disp_valid_i  in  1  dispatch entry valid.
- disp_ready_o  out  1  queue can accept an entry.
- disp_req_i  in  $bits(iq_fcc_req_t)  request payload; r0/r1 hold register-file data when ready.
- disp_rid_i  in  RID_W  destination ROB id.
- disp_src_tag_i  in  2*RID_W  source tags for r0 and r1.
- disp_src_rdy_i  in  2  per-source ready; when 1, payload data is valid.
- wkup_valid_i  in  WKUP_CNT  wakeup valid.
- wkup_tag_i  in  WKUP_CNT*RID_W  wakeup tags.
- wkup_data_i  in  WKUP_CNT*32  wakeup data.
- ex_req_valid_o  out  1  request to the fcc unit.
- ex_req_ready_i  in  1  fcc unit ready.
- ex_req_o  out  $bits(iq_fcc_req_t)  request with operands filled in.
- ex_resp_valid_i  in  1  response valid from the fcc unit.
- ex_resp_ready_o  out  1  response accepted.
- ex_resp_i  in  $bits(iq_fcc_resp_t)  response payload.
- wb_valid_o  out  1  writeback valid.
- wb_ready_i  in  1  writeback ready.
- wb_rid_o  out  RID_W  ROB id of the writeback.
- wb_resp_o  out  $bits(iq_fcc_resp_t)  forwarded response.

Behaviour:

Reset and flush
- On reset or flush_i, in the same cycle edge:
  - queue count, pointers and all entry valid/ready bits go to 0;
  - the in-flight tag FIFO is emptied.
- After reset or flush, every output reads 0 except disp_ready_o, which reads 1.
- Dispatch, issue and response handshakes occurring in a flush cycle are discarded.

Storage and pointers
- Circular buffer with head/tail pointers of width $clog2(DEPTH)+1.
- Empty when the pointers are fully equal.
- Full when the low bits match and the MSBs differ.
- Pointers wrap naturally with no special case.

Dispatch
- disp_ready_o = !full; it does not depend on a same-cycle dequeue.
- Enqueue on disp_valid_i && disp_ready_o.

Wakeup
- Every cycle, each valid entry source with rdy=0 compares its tag against every valid wkup port.
- On a match: capture wkup_data_i into r0 or r1 and set rdy=1.
- If several ports match, the lowest index wins.
- Wakeup also applies to the entry being enqueued that same cycle, so a source is never lost.

Issue
- Strictly in order: only the head entry may issue.
- ex_req_valid_o = head valid && both rdy && in-flight FIFO not full.
- Sources that an op does not use are dispatched with rdy=1.
- ex_req_o is combinational from the head entry.
- On ex_req_valid_o && ex_req_ready_i:
  - dequeue the head;
  - push the head's rid into the in-flight FIFO.
- Issue cannot happen on the same edge as the enqueue of that entry (bypass excepted).
- Simultaneous enqueue and dequeue while full is not possible, because ready excludes it. When not full, both take effect and count is unchanged.

Response and writeback
- The fcc unit returns responses in order, one cycle or more after acceptance.
- ex_resp_ready_o = wb_ready_i.
- wb_valid_o = ex_resp_valid_i.
- wb_resp_o = ex_resp_i.
- wb_rid_o = in-flight FIFO head.
- Pop the in-flight FIFO on ex_resp_valid_i && wb_ready_i.
- A push and a pop in the same cycle are both honoured.
- A response arriving while the in-flight FIFO is empty is a protocol error; an assertion flags it in simulation.

Optional Feature:
- Macro: WIRED_FCC_IQ_BYPASS_EN.
- With the macro defined, a dispatch issues directly in the same cycle when all of the following hold:
  - the queue is empty;
  - both sources are ready, counting same-cycle wakeup;
  - the in-flight FIFO is not full;
  - ex_req_ready_i = 1.
- In that case ex_req_o = the wakeup-merged disp_req_i and no entry is written.
- If the bypass handshake fails, the entry enqueues normally.
- Without the macro, minimum residency is one cycle: dispatch at cycle N issues no earlier than N+1.

Test Plan:
1. Reset, then dispatch fcmp with both rdy=1, rid=5, ex_req_ready_i=1 -> ex_req_valid_o=1 at N+1 (or at N with bypass). Response one cycle later -> wb_valid_o=1, wb_rid_o=5.
2. Dispatch fsel with r1 tag=9, rdy=0; two cycles later wkup tag=9, data=0x3F800000 -> issued r1=0x3F800000 one cycle after the wakeup. No issue before the wakeup.
3. Dispatch 4 entries with ex_req_ready_i=0 -> disp_ready_o=0 after the 4th. Raise ready -> entries issue in order with rids 1,2,3,4, and disp_ready_o=1 again after the first dequeue.
4. Issue 2 requests, hold ex_resp_valid_i=0 -> the third ready entry stays blocked (ex_req_valid_o=0). One response with wb_ready_i=1 -> the third issues the next cycle.
5. Queue holds 3 entries plus 1 in flight, assert flush_i -> next cycle count=0, ex_req_valid_o=0, wb_valid_o=0, disp_ready_o=1, and no stale rid appears in later writebacks.
6. Same-cycle dispatch of an entry with an r0 tag matching wkup port 1 -> entry enqueues with r0 rdy=1 and the captured data; issue follows at N+1.
